eqed_inj_ctrl: RTL
==================

Name: eqed_inj_ctrl

Overview:
Fault-injection controller that drives the per-flop EQED select lines of an instrumented design. Asserting a select line makes its inverting mux flip that flop's D input. The controller sits beside the instrumented module and accepts one injection request at a time: target flop index, start delay and hold duration. It pulses exactly one select line, then watches an external mismatch signal over an observation window and reports whether, and how fast, the bit flip was detected.

Parameters:
NUM_SEL, 8, number of EQED select lines (instrumented flops)
IDX_W, 3, width of the target index (clog2 of NUM_SEL, minimum 1)
DELAY_W, 8, width of the start-delay field
DUR_W, 4, width of the injection-duration field
OBS_LEN, 4, observation cycles after the select line deasserts (minimum 1)
LAT_W, 8, width of the detection-latency result
CNT_W, 16, width of the completed-injection counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
tgt_idx  in  IDX_W  select line to drive
delay  in  DELAY_W  cycles to wait before injecting
dur  in  DUR_W  cycles to hold the select line; 0 is treated as 1
abort  in  1  cancel the in-flight request
mismatch  in  1  error indication from the checker/duplicate compare
eqed_sel  out  NUM_SEL  registered select vector; one-hot or zero
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
detected  out  1  mismatch seen during the last completed request
det_lat  out  LAT_W  cycles from first select-assert cycle to first mismatch
req_err  out  1  one-cycle pulse: request rejected
inj_count  out  CNT_W  completed injections; saturating

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. eqed_sel, busy, done, detected, det_lat, req_err and inj_count all go to 0. Reset has priority over every input, including mid-injection; eqed_sel is 0 from the cycle after rst is sampled high.
- States: IDLE, WAIT, INJECT, OBSERVE, DONE.
- IDLE:
  - start=1 with tgt_idx < NUM_SEL is accepted. Call the accept cycle T0.
  - On accept, latch tgt_idx, delay and max(dur,1), clear detected and det_lat, and go to WAIT. If delay=0, go straight to INJECT.
  - start=1 with tgt_idx >= NUM_SEL: req_err pulses at T0+1 and the state stays IDLE.
- WAIT: occupies cycles T0+1 .. T0+delay, then goes to INJECT.
- INJECT:
  - Occupies cycles T0+delay+1 .. T0+delay+dur.
  - eqed_sel has bit tgt_idx set and all other bits 0 during exactly those cycles (registered, glitch-free).
- OBSERVE: occupies the OBS_LEN cycles after INJECT; eqed_sel is 0.
- DONE:
  - One cycle at T0+delay+dur+OBS_LEN+1. done=1 in that cycle.
  - inj_count increments in the same cycle, saturating at all-ones. The state returns to IDLE next.
- busy is 1 in WAIT, INJECT, OBSERVE and DONE.
- Detection:
  - mismatch is sampled in INJECT and OBSERVE cycles only.
  - On the first sampled 1, set detected and load det_lat = (current cycle − first INJECT cycle), saturating at 2^LAT_W−1.
  - Later mismatch pulses are ignored. Mismatch in IDLE or WAIT is ignored.
  - detected and det_lat hold their values until the next accepted start.
- start while busy is ignored (no error, no queueing), including on the DONE cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, eqed_sel=0, busy=0.
  - No done pulse and no inj_count increment. detected and det_lat keep their partial values.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort and mismatch in the same cycle: abort wins and the mismatch is not recorded.
  - rst together with anything: rst wins.
- Arithmetic: the delay and duration down-counters are unsigned and never wrap. The latency counter saturates.

Test Plan:
- Basic timing (OBS_LEN=4): start at cycle 0 with tgt_idx=3, delay=2, dur=1 -> eqed_sel=8'h08 in cycle 3 only; busy=1 in cycles 1–8; done=1 in cycle 8; inj_count=1.
- Detection latency: same request, mismatch=1 in cycles 5 and 6 -> detected=1, det_lat=2, values held after done. With no mismatch -> detected=0.
- Boundaries:
  - delay=0, dur=0, tgt_idx=7, start at cycle 0 -> eqed_sel=8'h80 in cycle 1 only; done in cycle 6.
  - dur=15 -> select held for 15 cycles.
  - tgt_idx=8 with NUM_SEL=9 is accepted; with NUM_SEL=8, tgt_idx=8 (requires IDX_W=4) -> req_err pulse, busy stays 0.
- Abort: delay=0, dur=10, abort in cycle 4 -> eqed_sel=0 and busy=0 from cycle 5; no done pulse; inj_count unchanged.
- Busy rejection and reset:
  - Second start during OBSERVE -> ignored.
  - rst asserted during INJECT -> all outputs 0 the next cycle, including inj_count.
- Saturation: drive inj_count to 16'hFFFF and complete another request -> inj_count stays FFFF. Mismatch later than 255 cycles after injection (LAT_W=8) -> det_lat=255.

Source files
------------

// File: rtl/eqed_inj_ctrl.sv
// eqed_inj_ctrl
// Fault-injection controller for EQED-instrumented designs. One request is
// handled at a time. After a programmable start delay it drives exactly one
// select line (flipping that flop's D input) for a programmable duration. It
// then watches the external mismatch flag over a fixed observation window
// and reports whether, and how quickly, the flip was detected.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      request strobe (sampled only when idle)
//   tgt_idx    select line to drive
//   delay      cycles to wait before injecting
//   dur        cycles to hold the select line (0 behaves as 1)
//   abort      cancel the in-flight request
//   mismatch   error flag from the checker / duplicate compare
//   eqed_sel   registered select vector, one-hot or zero
//   busy       request in progress
//   done       one-cycle completion pulse
//   detected   mismatch seen during the last request
//   det_lat    cycles from first select cycle to first mismatch (saturating)
//   req_err    one-cycle pulse for a rejected (out-of-range) request
//   inj_count  completed injections (saturating)
module eqed_inj_ctrl #(
  parameter int NUM_SEL = 8,
  parameter int IDX_W   = 3,
  parameter int DELAY_W = 8,
  parameter int DUR_W   = 4,
  parameter int OBS_LEN = 4,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   tgt_idx,
  input  logic [DELAY_W-1:0] delay,
  input  logic [DUR_W-1:0]   dur,
  input  logic               abort,
  input  logic               mismatch,
  output logic [NUM_SEL-1:0] eqed_sel,
  output logic               busy,
  output logic               done,
  output logic               detected,
  output logic [LAT_W-1:0]   det_lat,
  output logic               req_err,
  output logic [CNT_W-1:0]   inj_count
);

  localparam int OBS_W = $clog2(OBS_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT, INJECT, OBSERVE, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [DELAY_W-1:0] dly_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [OBS_W-1:0]   obs_cnt;
  // Cycles elapsed since the first INJECT cycle; 0 in that cycle.
  logic [LAT_W-1:0]   lat_cnt;

  function automatic logic [NUM_SEL-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_SEL-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (int'(i) == k) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] x);
    return (x == '1) ? x : x + LAT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  // Only the first mismatch of a request is recorded.
  function automatic logic first_hit(input logic mm, input logic det);
    return mm && !det;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      eqed_sel  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      detected  <= 1'b0;
      det_lat   <= '0;
      req_err   <= 1'b0;
      inj_count <= '0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort beats any same-cycle mismatch; partial detection results stay.
        state    <= IDLE;
        eqed_sel <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (int'(tgt_idx) < NUM_SEL) begin
                idx_q    <= tgt_idx;
                dly_cnt  <= delay;
                dur_cnt  <= (dur == '0) ? DUR_W'(1) : dur;
                lat_cnt  <= '0;
                detected <= 1'b0;
                det_lat  <= '0;
                busy     <= 1'b1;
                if (delay == '0) begin
                  state    <= INJECT;
                  eqed_sel <= onehot(tgt_idx);
                end else begin
                  state <= WAIT;
                end
              end else begin
                req_err <= 1'b1;
              end
            end
          end
          WAIT: begin
            // Select is registered on the transition so it rises exactly
            // with the first INJECT cycle.
            if (dly_cnt <= DELAY_W'(1)) begin
              state    <= INJECT;
              eqed_sel <= onehot(idx_q);
            end else begin
              dly_cnt <= dly_cnt - DELAY_W'(1);
            end
          end
          INJECT: begin
            if (first_hit(mismatch, detected)) begin
              detected <= 1'b1;
              det_lat  <= lat_cnt;
            end
            lat_cnt <= sat_inc_lat(lat_cnt);
            if (dur_cnt <= DUR_W'(1)) begin
              state    <= OBSERVE;
              eqed_sel <= '0;
              obs_cnt  <= OBS_W'(OBS_LEN);
            end else begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
          OBSERVE: begin
            if (first_hit(mismatch, detected)) begin
              detected <= 1'b1;
              det_lat  <= lat_cnt;
            end
            lat_cnt <= sat_inc_lat(lat_cnt);
            if (obs_cnt <= OBS_W'(1)) begin
              state     <= DONE;
              done      <= 1'b1;
              inj_count <= sat_inc_cnt(inj_count);
            end else begin
              obs_cnt <= obs_cnt - OBS_W'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            eqed_sel <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
